button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Input conditioning stage in front of the guitar-controller note reader. Takes the raw,
//  asynchronous, bouncing fret/strum lines from the GPIO header (plus KEY[0]) and makes them
//  clean. Per button: 2-flop synchronizer, stable-time debouncer, press/release pulse detect,
//  and a sticky press latch, so software polling over Avalon never misses a short strum.
//  btn_level feeds the note reader in place of raw GPIO_1/KEY.
// PARAMETERS
//  N_BTN            7        number of conditioned inputs (6 GPIO lines + KEY[0])
//  DEBOUNCE_CYCLES  500000   stable cycles required before a level change is accepted (10 ms @ 50 MHz); must be >= 1
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  per-button counter width (derived; do not override)
// PORTS
//  clk            in   1      system clock
//  reset          in   1      asynchronous, active-high reset
//  btn_raw        in   N_BTN  raw inputs, asynchronous to clk, 1 = pressed
//  latch_clear    in   N_BTN  per-bit clear of press_latched, sampled on clk
//  btn_level      out  N_BTN  debounced level, 1 = pressed
//  btn_press      out  N_BTN  one-cycle pulse on accepted 0->1 of btn_level
//  btn_release    out  N_BTN  one-cycle pulse on accepted 1->0 of btn_level
//  press_latched  out  N_BTN  sticky: set by btn_press, cleared by latch_clear
//  any_press      out  1      OR-reduce of press_latched (combinational from the registers)
// BEHAVIOUR
//  - Reset (async assert, release on clk): sync flops, counters, btn_level, btn_press,
//    btn_release, press_latched all 0; any_press 0.
//  - Sync: sync1 <= btn_raw; sync2 <= sync1. Only sync2 is used downstream.
//  - Debounce, per bit i, each clk edge:
//      sync2[i] == btn_level[i] : cnt[i] <= 0 (any glitch restarts the count)
//      sync2[i] != btn_level[i] and cnt[i] <  DEBOUNCE_CYCLES-1 : cnt[i] <= cnt[i]+1
//      sync2[i] != btn_level[i] and cnt[i] == DEBOUNCE_CYCLES-1 : btn_level[i] <= sync2[i]; cnt[i] <= 0
//  - Latency: count the first edge that samples a new stable raw value as edge 1.
//    btn_level changes after edge DEBOUNCE_CYCLES+2.
//  - A raw pulse or bounce shorter than DEBOUNCE_CYCLES consecutive sync2 cycles causes no change.
//  - Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//  - btn_press[i] / btn_release[i]: registered and high for exactly the one cycle in which
//    btn_level[i] has just taken its new value (same edge). Never both high. 0 otherwise.
//  - press_latched[i] next value: set if btn_press-update occurs this edge; else 0 if latch_clear[i];
//    else hold. Simultaneous set and clear on the same bit: set wins (no lost press).
//    Clearing one bit never affects other bits.
//  - Bits are fully independent. Simultaneous events on several bits are handled in parallel
//    with identical timing.
//  - Reset mid-count: all state cleared immediately. A button still held after reset release
//    is treated as a new press: btn_press fires DEBOUNCE_CYCLES+2 edges after release.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, N_BTN=7)
//  1. Assert reset, btn_raw=7'h7F -> all outputs 0 while reset high, including mid-cycle (async).
//  2. btn_raw[0] 0->1 held; call edge 1 the first sampling edge
//     -> btn_level[0]=1 after edge 6; btn_press[0]=1 for that one cycle only;
//        press_latched[0]=1; any_press=1.
//  3. btn_raw[2]: 1 for 3 cycles, 0 for 1 cycle, then 1 held
//     -> no change during the bounce; btn_level[2] rises 6 edges after the final 0->1.
//  4. From pressed, btn_raw[0] 1->0 held -> btn_level[0]=0 after edge 6;
//     btn_release[0] one cycle; press_latched[0] still 1.
//  5. latch_clear[0]=1 alone -> press_latched[0]=0 next cycle.
//     latch_clear[3]=1 on the same edge btn_press[3] fires -> press_latched[3]=1.
//  6. Hold btn_raw[5]=1, pulse reset during count and after acceptance
//     -> outputs 0 immediately; btn_press[5] fires 6 edges after reset release.
//     Random bouncing on all 7 bits checked against a per-bit reference model.

Source files
------------

// File: rtl/button_conditioner.sv
// Button conditioner: per-input 2-flop synchronizer, stable-time debouncer,
// press/release pulse detection and a sticky press latch for polled readers.
module button_conditioner #(
  parameter int N_BTN           = 7,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] latch_clear,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] press_latched,
  output logic             any_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_BTN-1:0]            sync1_q, sync1_d;
  logic [N_BTN-1:0]            sync2_q, sync2_d;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0]            level_q, level_d;
  logic [N_BTN-1:0]            press_q, press_d;
  logic [N_BTN-1:0]            release_q, release_d;
  logic [N_BTN-1:0]            latched_q, latched_d;

  // Next-state: synchronize, count stable mismatch cycles, detect edges, update latch
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    // A press on the same edge as a clear must survive so no strum is lost
    latched_d = press_d | (latched_q & ~latch_clear);
  end

  // State registers, all cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      latched_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      latched_q <= latched_d;
    end
  end

  assign btn_level     = level_q;
  assign btn_press     = press_q;
  assign btn_release   = release_q;
  assign press_latched = latched_q;
  assign any_press     = |latched_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with a short debounce time.
module tb_button_conditioner;

  localparam int N  = 7;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] latch_clear = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, press_latched;
  logic         any_press;

  int n_tests = 0;
  int n_fail  = 0;

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .latch_clear(latch_clear),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .press_latched(press_latched), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Reference model: level follows a raw value once the last DC samples seen
  // through the two-stage synchronizer all agree and differ from the level.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level, m_press, m_rel, m_lat;

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < DC + 2; k++) hist.push_back('0);
    m_level = '0; m_press = '0; m_rel = '0; m_lat = '0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] raw, input logic [N-1:0] clr);
    logic [N-1:0] nl;
    logic         v;
    bit           stable;
    int           sz;
    sz = hist.size();
    nl = m_level;
    for (int i = 0; i < N; i++) begin
      v = hist[sz-2][i];
      stable = 1'b1;
      for (int j = 2; j <= DC + 1; j++)
        if (hist[sz-j][i] != v) stable = 1'b0;
      if (stable && v != m_level[i]) nl[i] = v;
    end
    m_press = nl & ~m_level;
    m_rel   = m_level & ~nl;
    m_lat   = m_press | (m_lat & ~clr);
    m_level = nl;
    hist.push_back(raw);
    if (hist.size() > DC + 4) void'(hist.pop_front());
  endfunction

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_all();
    return {3'b0, btn_level, btn_press, btn_release, press_latched, any_press};
  endfunction

  // One clock: drive on falling edge, advance model at rising edge, sample 1 ns later
  task automatic tick(input logic [N-1:0] raw, input logic [N-1:0] clr);
    @(negedge clk);
    btn_raw = raw;
    latch_clear = clr;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(raw, clr);
    #1;
    expect_val("model", dut_all(), {3'b0, m_level, m_press, m_rel, m_lat, |m_lat});
  endtask

  // Asynchronous reset pulse in mid-cycle, held through one rising edge
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    expect_val("async_reset", dut_all(), 32'h0);
    model_reset();
    tick(btn_raw, '0);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] raw, clr, lvl, prs, rel, lat;
  } vec_t;
  vec_t tbl[$];

  logic [N-1:0] r;
  int run_len[N];

  initial begin
    // Test 2: press bit 0 (edges 1..7)
    for (int k = 1; k <= 5; k++) tbl.push_back('{7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00});
    tbl.push_back('{7'h01, 7'h00, 7'h01, 7'h01, 7'h00, 7'h01});
    tbl.push_back('{7'h01, 7'h00, 7'h01, 7'h00, 7'h00, 7'h01});
    // Test 4: release bit 0
    for (int k = 1; k <= 5; k++) tbl.push_back('{7'h00, 7'h00, 7'h01, 7'h00, 7'h00, 7'h01});
    tbl.push_back('{7'h00, 7'h00, 7'h00, 7'h00, 7'h01, 7'h01});
    tbl.push_back('{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01});
    // Test 5a: clear bit 0 alone
    tbl.push_back('{7'h00, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00});
    tbl.push_back('{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00});

    // Test 1: async reset with all inputs active, before any clock edge
    btn_raw = 7'h7F;
    #2;
    reset = 1'b1;
    #1;
    expect_val("reset_async_first", dut_all(), 32'h0);
    model_reset();
    tick(7'h7F, 7'h7F);
    tick(7'h7F, 7'h00);
    #2;
    expect_val("reset_midcycle", dut_all(), 32'h0);
    btn_raw = '0;
    reset = 1'b0;

    foreach (tbl[k]) begin
      tick(tbl[k].raw, tbl[k].clr);
      expect_val($sformatf("table_%0d", k),
                 {btn_level, btn_press, btn_release, press_latched, any_press},
                 {tbl[k].lvl, tbl[k].prs, tbl[k].rel, tbl[k].lat, |tbl[k].lat});
    end

    // Test 3: bit 2 bounces 1,1,1,0 then holds 1
    for (int k = 0; k < 3; k++) tick(7'h04, 7'h00);
    tick(7'h00, 7'h00);
    expect_val("bounce_hold", {btn_level[2], btn_press[2]}, 2'b00);
    for (int c = 1; c <= 8; c++) begin
      tick(7'h04, 7'h00);
      expect_val($sformatf("bounce_c%0d", c), {btn_level[2], btn_press[2]},
                 {c >= 6, c == 6});
    end

    // Test 5b: clear bit 3 on the very edge its press fires
    for (int c = 1; c <= 7; c++) begin
      tick(7'h0C, (c == 6) ? 7'h08 : 7'h00);
      if (c == 6) expect_val("press_vs_clear", {btn_press[3], press_latched[3]}, 2'b11);
    end
    expect_val("clear_isolation", press_latched, 7'h0C);

    // Test 6: bit 5 held across resets during count and after acceptance
    for (int k = 0; k < 3; k++) tick(7'h20, 7'h00);
    async_reset();
    for (int t = 1; t <= 8; t++) begin
      tick(7'h20, 7'h00);
      expect_val($sformatf("rst_count_t%0d", t), {btn_level[5], btn_press[5]}, {t >= 6, t == 6});
    end
    async_reset();
    for (int t = 1; t <= 8; t++) begin
      tick(7'h20, 7'h00);
      expect_val($sformatf("rst_accept_t%0d", t), {btn_level[5], btn_press[5]}, {t >= 6, t == 6});
    end

    // Random bouncing on all bits against the reference model
    r = btn_raw;
    for (int i = 0; i < N; i++) run_len[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (run_len[i] == 0) begin
          r[i] = 1'($urandom_range(0, 1));
          run_len[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 4);
        end
        run_len[i]--;
      end
      tick(r, ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00);
      if (n % 997 == 500) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
